// File: rtl/led_scan_if.sv
// CPU-side display register inputs and LED pin outputs of the scan driver.
interface led_scan_if #(
  parameter int unsigned DIGITS = 8
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank;
  logic                lz_en;
  logic                load;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   an;
  logic                frame_tick;

  modport master (
    output value, dp, blank, lz_en, load,
    input  seg, an, frame_tick
  );

  modport slave (
    input  value, dp, blank, lz_en, load,
    output seg, an, frame_tick
  );
endinterface

// File: rtl/led_scan_driver.sv
// Time-multiplexed seven-segment driver: hex glyphs, dp, blanking, leading-zero
// suppression, anti-ghost blank interval and frame-synchronous register update.
module led_scan_driver #(
  parameter int unsigned DIGITS        = 8,
  parameter int unsigned DIV           = 50000,
  parameter int unsigned BLANK_CYC     = 2,
  parameter bit          AN_ACTIVE_LOW = 1'b1
) (
  input logic       clk,
  input logic       reset,
  led_scan_if.slave bus
);
  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned RW = 6 * DIGITS + 1;
  localparam logic [DIGITS-1:0] AnOff = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [RW-1:0]     pend_q, pend_d;
  logic [RW-1:0]     act_q, act_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              tick_q, tick_d;

  // Register layout: {lz_en, blank, dp, value}
  logic [4*DIGITS-1:0] act_value;
  logic [DIGITS-1:0]   act_dp, act_blank;
  logic                act_lz;
  assign {act_lz, act_blank, act_dp, act_value} = act_q;

  logic slot_end, frame_end;

  always_comb begin
    slot_end  = (presc_q == PW'(DIV - 1));
    frame_end = slot_end && (idx_q == IW'(DIGITS - 1));
    presc_d   = slot_end ? '0 : presc_q + PW'(1);
    idx_d     = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    pend_d = bus.load ? {bus.lz_en, bus.blank, bus.dp, bus.value} : pend_q;
    // Commit takes the old pending value, so a same-cycle load waits a frame
    act_d  = frame_end ? pend_q : act_q;
  end

  logic [3:0]        nib;
  logic [6:0]        glyph;
  logic              lz_dark;
  logic [DIGITS-1:0] an_on;

  always_comb begin
    nib = act_value[4*idx_q +: 4];
    case (nib)
      4'h0: glyph = 7'h01;
      4'h1: glyph = 7'h4F;
      4'h2: glyph = 7'h12;
      4'h3: glyph = 7'h06;
      4'h4: glyph = 7'h4C;
      4'h5: glyph = 7'h24;
      4'h6: glyph = 7'h20;
      4'h7: glyph = 7'h0F;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h04;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h60;
      4'hC: glyph = 7'h31;
      4'hD: glyph = 7'h42;
      4'hE: glyph = 7'h30;
      default: glyph = 7'h38;
    endcase

    // Dark when this and every higher nibble is zero; digit 0 always shows
    lz_dark = act_lz && (idx_q != '0);
    for (int j = 0; j < int'(DIGITS); j++) begin
      if (j >= int'(idx_q) && act_value[4*j +: 4] != 4'h0) lz_dark = 1'b0;
    end

    an_on        = '0;
    an_on[idx_q] = 1'b1;

    seg_d  = 8'hFF;
    an_d   = AnOff;
    tick_d = frame_end;
    if (presc_q >= PW'(BLANK_CYC)) begin
      an_d = an_on ^ AnOff;
      if (!act_blank[idx_q]) begin
        seg_d = {~act_dp[idx_q], lz_dark ? 7'h7F : glyph};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      act_q   <= '0;
      seg_q   <= 8'hFF;
      an_q    <= AnOff;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: doc/led_scan_driver.md
Name: led_scan_driver

Overview:
- Time-multiplexed N-digit seven-segment display driver with a hex glyph decoder.
- Takes a packed 4-bit-per-digit value and scans one digit at a time onto a shared segment bus plus per-digit enables.
- Adds per-digit decimal point, per-digit blanking, leading-zero suppression, anti-ghosting blank interval and tear-free frame-synchronous update.
- Sits between the CPU's memory-mapped display register and the board's LED pins.

Parameters:
- DIGITS, 8, number of digits scanned; 1..16.
- DIV, 50000, clock cycles per digit slot; >= 4.
- BLANK_CYC, 2, cycles at the start of each slot with all anodes off; 0 <= BLANK_CYC < DIV.
- AN_ACTIVE_LOW, 1, 1 = anode enable driven low when on, 0 = driven high.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- value  in  4*DIGITS  hex nibbles; digit i = value[4i+3:4i]; digit 0 is least significant / rightmost.
- dp  in  DIGITS  decimal point on for digit i when dp[i]=1.
- blank  in  DIGITS  digit i fully dark when blank[i]=1.
- lz_en  in  1  leading-zero suppression enable.
- load  in  1  capture value/dp/blank/lz_en into pending register this cycle.
- seg  out  8  active-low; seg[7]=dp, seg[6:0]=a..g (a=bit6, g=bit0).
- an  out  DIGITS  digit enables, polarity per AN_ACTIVE_LOW.
- frame_tick  out  1  one-cycle pulse when pending is committed to active (slot 0 start).

Behaviour:
- Reset (sync, active-high): prescaler=0, idx=0, pending and active registers = 0, frame_tick=0, seg=8'hFF, an = all off. Reset mid-scan aborts the slot; the next cycle behaves as the first cycle after reset.
- Prescaler counts 0..DIV-1. At DIV-1 it wraps to 0 and idx advances (DIGITS-1 wraps to 0).
- load=1: pending <= inputs. Back-to-back loads are allowed; the last one wins.
- Commit: when prescaler wraps and idx wraps DIGITS-1 -> 0 (frame boundary), active <= pending and frame_tick pulses on that cycle. A load on the same cycle as commit goes to pending only; it displays next frame.
- After reset, the first frame displays active=0 (all glyph "0" subject to lz). The first commit happens at the end of that frame.
- Glyph table, seg[6:0], hex:
  - 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F
  - 8=00, 9=04, A=08, b=60, C=31, d=42, E=30, F=38
- Digit i is dark (seg[6:0]=7'h7F) when any of these holds:
  - blank[i]=1, or
  - lz_en=1, i>0, and all nibbles i..DIGITS-1 are 0 (non-blanked digits above are considered by value only).
- Digit 0 is never suppressed by lz.
- dp is independent of lz: seg[7] = ~dp[i] unless blank[i]=1 (then 1).
- Anti-ghost: while prescaler < BLANK_CYC, an = all off and seg = 8'hFF. Otherwise only an[idx] is on.
- Outputs are registered with 1-cycle latency: seg/an/frame_tick in cycle k reflect prescaler/idx/active of cycle k-1.
- Only one anode is ever on in any cycle; no glitch on an across slot changes.

Test Plan:
- DIGITS=4, DIV=8, BLANK_CYC=2, AN_ACTIVE_LOW=1:
  - Hold reset 3 cycles -> seg=FF, an=4'b1111, frame_tick=0.
  - Release reset -> first enabled slot shows an=4'b1110, seg=81 on cycles 3..8 after release.
- Load value=16'h12AF, lz_en=0, dp=0 -> after next frame_tick, slots 0..3 show seg = B8, 88, 92, CF with an = 1110, 1101, 1011, 0111 respectively, each preceded by 2 cycles of an=1111.
- Load value=16'h0030, lz_en=1 -> digits 3,2 dark (seg=FF, an still enabled), digit 1 seg=86, digit 0 seg=81. Load value=0 -> only digit 0 lit, seg=81.
- Load dp=4'b0100, blank=4'b0001 -> digit 2 seg[7]=0; digit 0 seg=FF even though value nibble is non-zero.
- Load issued mid-frame, then a second load on the frame_tick cycle -> the first value is displayed for the whole next frame with no mixed digits; the second value appears only in the following frame.
- Assert reset during slot 2 -> the next cycle shows seg=FF, an=1111, idx restarts at 0, and active=0 (glyph 81 on digit 0).
